// File: rtl/btn_debounce_repeat.sv
// Push-button conditioner: synchronises raw pads, debounces on divided-clock ticks,
// and emits clean levels plus press (with hold-to-repeat) and release pulses.
module btn_debounce_repeat #(
  parameter int unsigned NBTN        = 2,
  parameter int unsigned STABLE_CNT  = 4,
  parameter int unsigned REPEAT_DLY  = 16,
  parameter int unsigned REPEAT_RATE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_clk,
  input  logic [NBTN-1:0] btn_raw,
  output logic            tick,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release
);

  localparam int unsigned SW = $clog2(STABLE_CNT + 1);
  localparam int unsigned RW = 8;

  localparam logic [SW-1:0] STABLE_V = SW'(STABLE_CNT);
  localparam logic [RW-1:0] DLY_V    = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] RATE_V   = RW'(REPEAT_RATE);
  localparam logic          RPT_EN   = (REPEAT_DLY != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic tick_s1;
  logic tick_s2;
  logic tick_d;

  // Divided clock is only ever seen as a level; its rising edge becomes the sample strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_d  <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick_s1 <= tick_clk;
      tick_s2 <= tick_s1;
      tick_d  <= tick_s2;
      tick    <= tick_s2 & ~tick_d;
    end
  end

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    logic          s1;
    logic          s2;
    logic          level_q;
    logic          level_nxt;
    logic          press_q;
    logic          press_nxt;
    logic          release_q;
    logic          release_nxt;
    logic [SW-1:0] scnt_q;
    logic [SW-1:0] scnt_nxt;
    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] rcnt_nxt;
    state_t        state_q;
    state_t        state_nxt;
    logic          rise;
    logic          fall;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1        <= 1'b0;
        s2        <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        scnt_q    <= '0;
        rcnt_q    <= '0;
        state_q   <= IDLE;
      end else begin
        s1        <= btn_raw[g];
        s2        <= s1;
        level_q   <= level_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        scnt_q    <= scnt_nxt;
        rcnt_q    <= rcnt_nxt;
        state_q   <= state_nxt;
      end
    end

    // A new level is accepted only after STABLE_CNT consecutive differing samples.
    always_comb begin
      level_nxt = level_q;
      scnt_nxt  = scnt_q;
      if (tick) begin
        if (s2 != level_q) begin
          if (scnt_q + SW'(1) == STABLE_V) begin
            level_nxt = ~level_q;
            scnt_nxt  = '0;
          end else begin
            scnt_nxt = scnt_q + SW'(1);
          end
        end else begin
          scnt_nxt = '0;
        end
      end
    end

    assign rise = level_nxt & ~level_q;
    assign fall = ~level_nxt & level_q;

    // Pulses are decided from the next level so they land on the same edge as the level change.
    always_comb begin
      state_nxt   = state_q;
      rcnt_nxt    = rcnt_q;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            press_nxt = 1'b1;
            state_nxt = HOLD;
            rcnt_nxt  = '0;
          end
        end
        HOLD: begin
          if (fall) begin
            release_nxt = 1'b1;
            state_nxt   = IDLE;
            rcnt_nxt    = '0;
          end else if (tick && RPT_EN) begin
            if (rcnt_q + RW'(1) == DLY_V) begin
              press_nxt = 1'b1;
              state_nxt = REPEAT;
              rcnt_nxt  = '0;
            end else begin
              rcnt_nxt = rcnt_q + RW'(1);
            end
          end
        end
        REPEAT: begin
          if (fall) begin
            release_nxt = 1'b1;
            state_nxt   = IDLE;
            rcnt_nxt    = '0;
          end else if (tick) begin
            if (rcnt_q + RW'(1) == RATE_V) begin
              press_nxt = 1'b1;
              rcnt_nxt  = '0;
            end else begin
              rcnt_nxt = rcnt_q + RW'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
  end

endmodule
